seven_seg_scan_mux: RTL and testbench

//   Time-multiplexes the eight latched 7-seg byte registers (ss0..ss7 from the bus-mapped

---
 rtl/seven_seg_scan_mux.sv | 157 +++++++++++++++
 tb/tb_seven_seg_scan_mux.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_mux.sv
// seven_seg_scan_mux: scans eight latched 7-segment patterns onto one shared
// segment bus with one-hot digit selects. Each digit slot starts with a short
// blanking gap (anti-ghosting) and ends with a PWM-dimmed show phase. All
// inputs are snapshotted once per frame so a frame never mixes old and new data.
//
// Interface timing: there is no handshake. seg_out, dig_sel and frame_tick
// are registered and valid every cycle. They reflect the FSM state of the
// previous cycle. frame_tick is a single-cycle pulse.
module seven_seg_scan_mux #(
  parameter int CLK_DIV        = 16,
  parameter int BLANK_CYCLES   = 2,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       enable,
  input  logic [2:0] brightness,
  input  logic [7:0] ss0,
  input  logic [7:0] ss1,
  input  logic [7:0] ss2,
  input  logic [7:0] ss3,
  input  logic [7:0] ss4,
  input  logic [7:0] ss5,
  input  logic [7:0] ss6,
  input  logic [7:0] ss7,
  output logic [7:0] seg_out,
  output logic [7:0] dig_sel,
  output logic       frame_tick,
  output logic [1:0] state_dbg
);

  localparam int CNT_W    = $clog2(CLK_DIV);
  localparam int SHOW_LEN = CLK_DIV - BLANK_CYCLES;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  // An XOR mask applies the output polarity. The off level is the mask itself.
  localparam logic [7:0] SEG_MASK = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [7:0] DIG_MASK = (DIG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] SHOW  = 2'd2;

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic [2:0]       bright_q;
  logic [7:0]       snap [8];
  logic             take_snap;
  logic             frame_end;
  logic             lit;
  int               lit_end;
  logic [7:0]       seg_n;
  logic [7:0]       dig_n;

  assign state_dbg = state;

  // Next-state logic for the scan FSM. enable=0 forces IDLE from any state.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    take_snap = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
      idx_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n   = BLANK;
          cnt_n     = '0;
          idx_n     = '0;
          take_snap = 1'b1;
        end
        BLANK: begin
          cnt_n = cnt + 1'b1;
          if (cnt == BLANK_LAST) state_n = SHOW;
        end
        SHOW: begin
          if (cnt == CNT_LAST) begin
            cnt_n     = '0;
            state_n   = BLANK;
            idx_n     = idx + 1'b1;
            take_snap = (idx == 3'd7);
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          idx_n   = '0;
        end
      endcase
    end
  end

  // Pre-register output decode. The digit is lit for the first ON_LEN cycles
  // of SHOW. brightness=7 gives an ON_LEN equal to the whole show phase.
  always_comb begin
    lit_end   = BLANK_CYCLES + (SHOW_LEN * (int'(bright_q) + 1)) / 8;
    lit       = enable && (state == SHOW) && (int'(cnt) < lit_end);
    frame_end = enable && (state == SHOW) && (cnt == CNT_LAST) && (idx == 3'd7);
    seg_n     = lit ? snap[idx] : 8'h00;
    dig_n     = lit ? (8'b1 << idx) : 8'h00;
  end

  // State, slot counter and digit index registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
  end

  // Per-frame snapshot of the patterns and the brightness. It is taken when
  // leaving IDLE and on each frame wrap.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < 8; i++) snap[i] <= 8'h00;
      bright_q <= 3'd7;
    end else if (take_snap) begin
      snap[0]  <= ss0;
      snap[1]  <= ss1;
      snap[2]  <= ss2;
      snap[3]  <= ss3;
      snap[4]  <= ss4;
      snap[5]  <= ss5;
      snap[6]  <= ss6;
      snap[7]  <= ss7;
      bright_q <= brightness;
    end
  end

  // Registered outputs. Reset drives them to the off level asynchronously.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      seg_out    <= SEG_MASK;
      dig_sel    <= DIG_MASK;
      frame_tick <= 1'b0;
    end else begin
      seg_out    <= seg_n ^ SEG_MASK;
      dig_sel    <= dig_n ^ DIG_MASK;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Bench for seven_seg_scan_mux. Two instances run side by side on the same
// inputs: one with active-high polarity and one with active-low polarity.
// The driver issues stimulus at negedges. For every output cycle it pushes the
// hand-derived response {frame_tick, dig_sel, seg_out} into exp_q. A monitor
// pops one entry each cycle, 1 ns after posedge, and compares both instances.
module tb_seven_seg_scan_mux;

  logic       clk;
  logic       nrst;
  logic       enable;
  logic [2:0] brightness;
  logic [7:0] ss [8];

  logic [7:0] seg_hi, dig_hi, seg_lo, dig_lo;
  logic       tick_hi, tick_lo;
  logic [1:0] st_hi, st_lo;

  logic [16:0] exp_q[$];
  logic [7:0]  exp_pat [8];
  int          n_total = 0;
  int          n_pass  = 0;

  seven_seg_scan_mux #(.CLK_DIV(16), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) u_dut_hi (
    .clk(clk), .nrst(nrst), .enable(enable), .brightness(brightness),
    .ss0(ss[0]), .ss1(ss[1]), .ss2(ss[2]), .ss3(ss[3]),
    .ss4(ss[4]), .ss5(ss[5]), .ss6(ss[6]), .ss7(ss[7]),
    .seg_out(seg_hi), .dig_sel(dig_hi), .frame_tick(tick_hi), .state_dbg(st_hi)
  );

  seven_seg_scan_mux #(.CLK_DIV(16), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) u_dut_lo (
    .clk(clk), .nrst(nrst), .enable(enable), .brightness(brightness),
    .ss0(ss[0]), .ss1(ss[1]), .ss2(ss[2]), .ss3(ss[3]),
    .ss4(ss[4]), .ss5(ss[5]), .ss6(ss[6]), .ss7(ss[7]),
    .seg_out(seg_lo), .dig_sel(dig_lo), .frame_tick(tick_lo), .state_dbg(st_lo)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h, required %h", name, $time, act, exp);
  endtask

  // Expected-response builders. Each entry is {tick, dig_sel, seg_out} in active-high form.
  task automatic push_off(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(17'h0);
  endtask

  // One 16-cycle slot: 2 blank, on_len lit, the rest dark. Only the first
  // n_ent entries are pushed. When tick is set, the last entry carries it.
  task automatic push_slot(input int d, input logic [7:0] pat, input int on_len,
                           input bit tick, input int n_ent);
    logic [7:0] onehot;
    logic [16:0] e;
    onehot = 8'h01 << d;
    for (int c = 0; c < n_ent; c++) begin
      if (c >= 2 && c < 2 + on_len) e = {1'b0, onehot, pat};
      else                          e = 17'h0;
      if (tick && c == 15) e[16] = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_frame(input int on_len);
    for (int d = 0; d < 8; d++) push_slot(d, exp_pat[d], on_len, d == 7, 16);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor: one popped expectation per output cycle, checked on both instances.
  initial begin
    logic [16:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scan_hi", {tick_hi, dig_hi, seg_hi}, e);
        check("scan_lo", {tick_lo, dig_lo, seg_lo}, {e[16], ~e[15:8], ~e[7:0]});
      end
    end
  end

  // Driver: directed phases.
  initial begin
    nrst       = 1'b1;
    enable     = 1'b0;
    brightness = 3'd7;
    ss[0] = 8'h3F; ss[1] = 8'h06; ss[2] = 8'h5B; ss[3] = 8'h4F;
    ss[4] = 8'h66; ss[5] = 8'h6D; ss[6] = 8'h7D; ss[7] = 8'h07;
    exp_pat[0] = 8'h3F; exp_pat[1] = 8'h06; exp_pat[2] = 8'h5B; exp_pat[3] = 8'h4F;
    exp_pat[4] = 8'h66; exp_pat[5] = 8'h6D; exp_pat[6] = 8'h7D; exp_pat[7] = 8'h07;
    #2 nrst = 1'b0;
    step(2);

    // Reset state: both instances at their off levels, no tick.
    check("reset_hi", {tick_hi, dig_hi, seg_hi}, 17'h0);
    check("reset_lo", {tick_lo, dig_lo, seg_lo}, {1'b0, 8'hFF, 8'hFF});
    nrst = 1'b1;
    push_off(2);
    step(2);

    // Full brightness: two frames, with the tick on the final cycle of each 128-cycle frame.
    enable = 1'b1;
    push_off(1);
    push_frame(14);
    step(128);
    push_frame(14);
    step(128);

    // brightness=3 gives 7 lit cycles per slot. The new value is set before the frame wrap.
    brightness = 3'd3;
    push_frame(7);
    step(128);

    // brightness=0 gives 1 lit cycle per slot.
    brightness = 3'd0;
    push_frame(1);
    step(128);

    // Snapshot: ss2 and ss6 change while digit 4 shows. The old values stay until the next frame.
    brightness = 3'd7;
    push_frame(14);
    step(70);
    ss[2] = 8'h7F;
    ss[6] = 8'h71;
    step(58);
    exp_pat[2] = 8'h7F;
    exp_pat[6] = 8'h71;
    push_frame(14);
    step(128);

    // enable drops in digit 5 after 4 lit cycles: dark on the next cycle and no tick.
    for (int d = 0; d < 5; d++) push_slot(d, exp_pat[d], 14, 1'b0, 16);
    push_slot(5, exp_pat[5], 14, 1'b0, 6);
    step(87);
    enable = 1'b0;
    push_off(4);
    step(4);

    // Re-enable: scanning restarts at digit 0.
    enable = 1'b1;
    push_off(1);
    push_frame(14);
    step(129);
    enable = 1'b0;
    push_off(2);
    step(2);

    // nrst pulse in digit 3: outputs go off immediately, then the scan restarts at digit 0.
    brightness = 3'd2;
    enable = 1'b1;
    push_off(1);
    for (int d = 0; d < 3; d++) push_slot(d, exp_pat[d], 5, 1'b0, 16);
    push_slot(3, exp_pat[3], 5, 1'b0, 5);
    step(54);
    nrst = 1'b0;
    #1;
    check("async_rst_hi", {tick_hi, dig_hi, seg_hi}, 17'h0);
    check("async_rst_lo", {tick_lo, dig_lo, seg_lo}, {1'b0, 8'hFF, 8'hFF});
    step(2);
    nrst = 1'b1;
    push_off(1);
    push_frame(5);
    step(129);
    enable = 1'b0;
    push_off(2);
    step(2);

    check("queue_drained", 17'(exp_q.size()), 17'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
